// File: rtl/comb_bool_eval.sv
// Y = A&B | ~B&C computed three ways (gates, NAND-only, expression), cross-checked,
// with a self-test operand sweep, registered Y and sticky disagreement flag.
module comb_bool_eval (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       self_test,
  output logic [2:0] count,
  output wire        y_struct,
  output wire        y_nand,
  output logic       y_cont,
  output logic       mismatch,
  output logic       y_reg,
  output logic       err_sticky,
  output logic       sweep_done
);

  logic [2:0] count_q, count_d;
  logic       y_reg_q, y_reg_d;
  logic       err_q, err_d;
  logic       sweep_q, sweep_d;
  logic       op_a, op_b, op_c;

  // Operand source switches combinationally; the counter itself is untouched.
  assign {op_a, op_b, op_c} = self_test ? count_q : {a, b, c};

  wire s_nb, s_t1, s_t2;
  not g_s_nb (s_nb, op_b);
  and g_s_t1 (s_t1, op_a, op_b);
  and g_s_t2 (s_t2, s_nb, op_c);
  or  g_s_y  (y_struct, s_t1, s_t2);

  wire nand_n1, nand_nb, nand_n2;
  nand g_n1 (nand_n1, op_a, op_b);
  nand g_nb (nand_nb, op_b, op_b);
  nand g_n2 (nand_n2, nand_nb, op_c);
  nand g_ny (y_nand, nand_n1, nand_n2);

  assign y_cont   = (op_a & op_b) | (~op_b & op_c);
  assign mismatch = (y_struct ^ y_nand) | (y_nand ^ y_cont);

  always_comb begin
    count_d = count_q;
    sweep_d = 1'b0;
    if (self_test) begin
      count_d = count_q + 3'd1;
      sweep_d = (count_q == 3'd7);
    end
    y_reg_d = y_cont;
    err_d   = err_q | mismatch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 3'd0;
      y_reg_q <= 1'b0;
      err_q   <= 1'b0;
      sweep_q <= 1'b0;
    end else begin
      count_q <= count_d;
      y_reg_q <= y_reg_d;
      err_q   <= err_d;
      sweep_q <= sweep_d;
    end
  end

  assign count      = count_q;
  assign y_reg      = y_reg_q;
  assign err_sticky = err_q;
  assign sweep_done = sweep_q;

endmodule

// File: tb/tb_comb_bool_eval.sv
// Directed bench for comb_bool_eval: reset, sweep, external mode, latency,
// mode switch and a forced NAND fault to exercise the sticky error flag.
module tb_comb_bool_eval;
  logic       clk = 1'b0;
  logic       rst_n, a, b, c, self_test;
  logic [2:0] count;
  wire        y_struct, y_nand;
  logic       y_cont, mismatch, y_reg, err_sticky, sweep_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] tv = 8'hE2;

  comb_bool_eval dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .self_test(self_test),
    .count(count), .y_struct(y_struct), .y_nand(y_nand), .y_cont(y_cont),
    .mismatch(mismatch), .y_reg(y_reg), .err_sticky(err_sticky),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_ys(input string tag, input logic exp);
    check_eq({tag, "_struct"}, {7'd0, y_struct}, {7'd0, exp});
    check_eq({tag, "_nand"},   {7'd0, y_nand},   {7'd0, exp});
    check_eq({tag, "_cont"},   {7'd0, y_cont},   {7'd0, exp});
  endtask

  logic [2:0] ext_v [4] = '{3'b001, 3'b011, 3'b110, 3'b100};
  logic       ext_y [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0; self_test = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_count", {5'd0, count}, 8'd0);
    check_eq("rst_yreg",  {7'd0, y_reg}, 8'd0);
    check_eq("rst_err",   {7'd0, err_sticky}, 8'd0);
    check_eq("rst_sweep", {7'd0, sweep_done}, 8'd0);
    rst_n = 1'b1;

    // Sweep: 10 samples, wrap at sample 8
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("sw_count", {5'd0, count}, 8'(i % 8));
      check_ys("sw_y", tv[i % 8]);
      check_eq("sw_mismatch", {7'd0, mismatch}, 8'd0);
      check_eq("sw_err", {7'd0, err_sticky}, 8'd0);
      check_eq("sw_sweep", {7'd0, sweep_done}, {7'd0, i == 8});
      check_eq("sw_yreg", {7'd0, y_reg}, {7'd0, (i == 0) ? 1'b0 : tv[(i - 1) % 8]});
      $display("sweep i=%0d count=%0d y=%b%b%b sweep_done=%b", i, count, y_struct, y_nand, y_cont, sweep_done);
      @(negedge clk);
    end

    // Mode switch at count 3
    @(negedge clk);
    check_eq("ms_count3", {5'd0, count}, 8'd3);
    self_test = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("ms_hold", {5'd0, count}, 8'd3);
      check_eq("ms_hold_sweep", {7'd0, sweep_done}, 8'd0);
    end
    self_test = 1'b1;
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      check_eq("ms_resume", {5'd0, count}, 8'(k % 8));
      check_eq("ms_sweep", {7'd0, sweep_done}, {7'd0, k == 8});
    end

    // External mode
    self_test = 1'b0;
    for (int v = 0; v < 4; v++) begin
      {a, b, c} = ext_v[v];
      #1;
      check_ys("ext_y", ext_y[v]);
      @(negedge clk);
      check_eq("ext_yreg", {7'd0, y_reg}, {7'd0, ext_y[v]});
      check_eq("ext_count", {5'd0, count}, 8'd0);
      $display("ext abc=%b y=%b y_reg=%b", ext_v[v], y_cont, y_reg);
    end

    // Latency: step 000 -> 101 just before an edge
    {a, b, c} = 3'b000;
    @(negedge clk);
    #3;
    {a, b, c} = 3'b101;
    #1;
    check_eq("lat_ycont", {7'd0, y_cont}, 8'd1);
    check_eq("lat_yreg_before", {7'd0, y_reg}, 8'd0);
    @(posedge clk);
    #1;
    check_eq("lat_yreg_after", {7'd0, y_reg}, 8'd1);

    // Error latch via forced NAND net
    @(negedge clk);
    {a, b, c} = 3'b000;
    #1;
    check_eq("err_pre_mismatch", {7'd0, mismatch}, 8'd0);
    force dut.nand_n1 = 1'b0;
    #1;
    check_eq("err_ynand", {7'd0, y_nand}, 8'd1);
    check_eq("err_mismatch", {7'd0, mismatch}, 8'd1);
    check_eq("err_not_yet", {7'd0, err_sticky}, 8'd0);
    @(posedge clk);
    #1;
    release dut.nand_n1;
    #1;
    check_eq("err_set", {7'd0, err_sticky}, 8'd1);
    check_eq("err_mismatch_gone", {7'd0, mismatch}, 8'd0);
    repeat (2) @(negedge clk);
    check_eq("err_hold", {7'd0, err_sticky}, 8'd1);
    rst_n = 1'b0;
    #1;
    check_eq("err_clear", {7'd0, err_sticky}, 8'd0);
    {a, b, c} = 3'b111;
    #1;
    check_ys("rst_comb", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
